cla96_pipe_adder: RTL and testbench

Two-stage pipelined 96-bit carry-lookahead adder for the butterfly datapath. It produces the bit-level and 4-bit-group propagate/generate terms that feed the lookahead carry generators, registers them, and resolves the carries into a 96-bit sum with carry-out. A valid/ready handshake lets it sit between the twiddle-multiplier output and the butterfly accumulate stage under backpressure.

---
 rtl/cla96_pipe_adder.sv | 138 +++++++++++++
 tb/tb_cla96_pipe_adder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cla96_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with a valid/ready handshake.
// Optional subtract path is enabled by defining CLA96_SUB_EN.
module cla96_pipe_adder #(
  parameter int WIDTH = 96,
  parameter int GRP   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             ovf_out
);
  localparam int NG = WIDTH / GRP;
  localparam int NS = NG / 4;

  logic             s1_valid_q, s2_valid_q;
  logic [WIDTH-1:0] p_q, g_q;
  logic [NG-1:0]    gp_q, gg_q;
  logic             cin_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic s2_adv, s1_adv, s1_load;
  assign s2_adv  = ~s2_valid_q | out_ready;
  assign s1_adv  = ~s1_valid_q | s2_adv;
  assign s1_load = in_valid & s1_adv;

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign sum_out   = sum_q;
  assign c_out     = cout_q;
  assign ovf_out   = ovf_q;

  // ---------------- Stage 1: bit and group propagate/generate
  logic [WIDTH-1:0] b_eff, p_d, g_d;
  logic [NG-1:0]    gp_d, gg_d;
  logic             cin_d;

`ifdef CLA96_SUB_EN
  assign b_eff = sub_in ? ~b_in : b_in;
  assign cin_d = sub_in | c_in;
`else
  logic unused_sub;
  assign unused_sub = sub_in;
  assign b_eff      = b_in;
  assign cin_d      = c_in;
`endif

  assign p_d = a_in ^ b_eff;
  assign g_d = a_in & b_eff;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic [3:0] p, g;
    assign p       = p_d[GRP*k +: GRP];
    assign g       = g_d[GRP*k +: GRP];
    assign gp_d[k] = &p;
    assign gg_d[k] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

  always_ff @(posedge clk) begin
    if (rst)         s1_valid_q <= 1'b0;
    else if (s1_adv) s1_valid_q <= in_valid;
  end

  // Payload only moves on an accepted beat, so it holds while S1 is stalled.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      p_q   <= p_d;
      g_q   <= g_d;
      gp_q  <= gp_d;
      gg_q  <= gg_d;
      cin_q <= cin_d;
    end
  end

  // ---------------- Stage 2: carry resolution and sum
  logic [WIDTH-1:0] cv;       // carry into each bit
  logic             cout_d, ovf_d;
  logic [WIDTH-1:0] sum_d;

  always_comb begin
    logic       c, cg;
    logic [3:0] sp, sg, gci;
    cv  = '0;
    sp  = '0;
    sg  = '0;
    gci = '0;
    cg  = 1'b0;
    c   = cin_q;
    for (int s = 0; s < NS; s++) begin
      sp     = gp_q[4*s +: 4];
      sg     = gg_q[4*s +: 4];
      gci[0] = c;
      gci[1] = sg[0] | (sp[0] & c);
      gci[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & c);
      gci[3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0]) | (sp[2] & sp[1] & sp[0] & c);
      // super-group carry-out ripples into the next block
      c = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1]) | (sp[3] & sp[2] & sp[1] & sg[0])
        | (sp[3] & sp[2] & sp[1] & sp[0] & c);
      for (int j = 0; j < 4; j++) begin
        cg = gci[j];
        for (int b = 0; b < GRP; b++) begin
          cv[(4*s+j)*GRP + b] = cg;
          cg = g_q[(4*s+j)*GRP + b] | (p_q[(4*s+j)*GRP + b] & cg);
        end
      end
    end
    cout_d = c;
  end

  assign sum_d = p_q ^ cv;
  assign ovf_d = cv[WIDTH-1] ^ cout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_cla96_pipe_adder.sv
// Directed-vector bench for cla96_pipe_adder: latency, streaming, stall, toggle, reset.
module tb_cla96_pipe_adder;
  localparam int W  = 96;
  localparam int NV = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, c_in, sub_in, out_valid, out_ready, c_out, ovf_out;
  logic [W-1:0] a_in, b_in, sum_out;

  cla96_pipe_adder #(.WIDTH(W), .GRP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .sub_in(sub_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .c_out(c_out), .ovf_out(ovf_out)
  );

  always #5 clk = ~clk;

  logic [W-1:0] va[NV], vb[NV];
  logic         vc[NV];
  logic [W+1:0] vexp[NV];     // {ovf, cout, sum}
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W+1:0] res();
    return {ovf_out, c_out, sum_out};
  endfunction

  task automatic setv(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic ov, input logic co, input logic [W-1:0] s);
    va[i] = a; vb[i] = b; vc[i] = c; vexp[i] = {ov, co, s};
  endtask

  task automatic drv(input int i);
    a_in = va[i]; b_in = vb[i]; c_in = vc[i]; sub_in = 1'b0; in_valid = 1'b1;
  endtask

  // One isolated beat: checks out_valid after the first edge is low, then the result.
  task automatic one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic c, input logic s, input logic [W+1:0] exp);
    a_in = a; b_in = b; c_in = c; sub_in = s; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0; sub_in = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    tick;
    chk({tag, "_vld"}, out_valid, 1);
    chk(tag, res(), exp);
    tick;
  endtask

  initial begin
    setv(0, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 96'h1, 0, 0, 1, 96'h0);
    setv(1, 96'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF, 96'h1, 0, 1, 0, 96'h8000_0000_0000_0000_0000_0000);
    setv(2, 96'h0, 96'h0, 1, 0, 0, 96'h1);
    setv(3, 96'h8000_0000_0000_0000_0000_0000, 96'h8000_0000_0000_0000_0000_0000, 0, 1, 1, 96'h0);
    setv(4, 96'h0123_4567_89AB_CDEF_0123_4567, 96'hFEDC_BA98_7654_3210_FEDC_BA98, 0, 0, 0,
         96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    setv(5, 96'h0123_4567_89AB_CDEF_0123_4567, 96'hFEDC_BA98_7654_3210_FEDC_BA98, 1, 0, 1, 96'h0);
    setv(6, 96'h0000_0000_0000_0000_0000_FFFF, 96'h1, 0, 0, 0, 96'h0000_0000_0000_0000_0001_0000);
    setv(7, 96'h0000_0000_FFFF_FFFF_FFFF_FFFF, 96'h0, 1, 0, 0, 96'h0000_0001_0000_0000_0000_0000);
    setv(8, 96'h1234_5678_9ABC_DEF0_1111_2222, 96'h1111_1111_1111_1111_1111_1111, 0, 0, 0,
         96'h2345_6789_ABCD_F001_2222_3333);
    setv(9, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1, 0, 1,
         96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF);

    // Reset with a beat presented: it must be dropped.
    rst = 1'b1; out_ready = 1'b1; drv(0);
    tick; tick;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_ovld", out_valid, 0);
    chk("rst_irdy", in_ready, 1);
    chk("rst_res", res(), 0);
    tick; tick;
    chk("rst_drop", out_valid, 0);

    // Isolated beats: latency and boundary vectors.
    one("allones_p1", va[0], vb[0], vc[0], 0, vexp[0]);
    one("max_pos_p1", va[1], vb[1], vc[1], 0, vexp[1]);
`ifdef CLA96_SUB_EN
    one("sub_5m7", 96'd5, 96'd7, 0, 1, {1'b0, 1'b0, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFE});
    one("sub_7m5", 96'd7, 96'd5, 0, 1, {1'b0, 1'b1, 96'h2});
    one("sub_cin_ign", 96'd7, 96'd5, 1, 1, {1'b0, 1'b1, 96'h2});
`else
    one("sub_ignored", 96'd5, 96'd7, 0, 1, {1'b0, 1'b0, 96'hC});
`endif

    // Back-to-back stream, one result per cycle in order.
    for (int k = 0; k <= NV; k++) begin
      if (k < NV) drv(k); else in_valid = 1'b0;
      tick;
      if (k >= 1) begin
        chk($sformatf("strm_vld%0d", k - 1), out_valid, 1);
        chk($sformatf("strm%0d", k - 1), res(), vexp[k - 1]);
      end
    end
    tick;
    chk("strm_end", out_valid, 0);

    // Stall: two beats in flight, a third waiting at the input.
    out_ready = 1'b0;
    drv(4); tick;
    drv(6); tick;
    drv(8);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_irdy%0d", k), in_ready, 0);
      chk($sformatf("stall_hold%0d", k), res(), vexp[4]);
      tick;
    end
    chk("stall_vld", out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("release_irdy", in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("drain0", res(), vexp[6]);
    tick;
    chk("drain1_vld", out_valid, 1);
    chk("drain1", res(), vexp[8]);
    tick;
    chk("drain_end", out_valid, 0);

    // Irregular input and output handshakes, checked against an in-order queue.
    begin
      int q[$];
      int sent = 0, got = 0;
      for (int cyc = 0; cyc < 80 && got < NV; cyc++) begin
        if (sent < NV && (cyc % 4) != 2) drv(sent); else in_valid = 1'b0;
        out_ready = (cyc % 3) != 1;
        #1;
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("tog_spurious", 1, 0);
          else begin
            chk($sformatf("tog%0d", q[0]), res(), vexp[q[0]]);
            void'(q.pop_front());
            got++;
          end
        end
        if (in_valid && in_ready) begin
          q.push_back(sent);
          sent++;
        end
        tick;
      end
      in_valid = 1'b0;
      chk("tog_count", got, NV);
    end
    out_ready = 1'b1;
    tick; tick;

    // Reset mid-flight: both beats discarded, a beat during reset dropped.
    out_ready = 1'b0;
    drv(8); tick;
    drv(3); tick;
    chk("pre_rst_vld", out_valid, 1);
    rst = 1'b1; drv(0);
    tick;
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_irdy", in_ready, 1);
    chk("mid_rst_res", res(), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("mid_rst_quiet%0d", k), out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
